// File: rtl/delay_sched_pkg.sv
// Shared types and helpers for the delay slot scheduler and related multi-requester blocks.
// Holds the slot state encoding, default sizing and round-robin pointer arithmetic.
package delay_sched_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } sched_state_t;

    localparam int unsigned DefNReq = 4;
    localparam int unsigned DefCntW = 8;

    // Pointer to the requester after idx, wrapping at n.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        if (idx + 1 >= n) begin
            return 0;
        end
        return idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from i_ptr with wrap for the first
// active request and returns it one-hot plus as an index. No grant while i_en is low.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    input  logic             i_en,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0] o_gnt_idx
);

    logic        w_found;
    int unsigned w_idx;

    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        w_found   = 1'b0;
        w_idx     = 0;
        if (i_en) begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                w_idx = (32'(i_ptr) + k) % N_REQ;
                if (!w_found && i_req[w_idx]) begin
                    w_found        = 1'b1;
                    o_gnt[w_idx]   = 1'b1;
                    o_gnt_idx      = IDX_W'(w_idx);
                end
            end
        end
    end

endmodule

// File: rtl/delay_slot_scheduler.sv
// Shares one down-counter among N_REQ requesters: grants one request at a time round-robin,
// counts the requested delay to zero and pulses done to the slot owner.
module delay_slot_scheduler
    import delay_sched_pkg::*;
#(
    parameter int unsigned N_REQ = DefNReq,
    parameter int unsigned CNT_W = DefCntW,
    parameter int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       i_req_valid,
    input  logic [N_REQ*CNT_W-1:0] i_req_delay,
    output logic [N_REQ-1:0]       o_req_ready,
    input  logic                   i_abort,
    output logic [N_REQ-1:0]       o_done,
    output logic                   o_busy,
    output logic [IDX_W-1:0]       o_owner,
    output logic [CNT_W-1:0]       o_count
);

    sched_state_t     r_state;
    logic [CNT_W-1:0] r_count;
    logic [IDX_W-1:0] r_owner;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [N_REQ-1:0] r_done;
    logic             r_busy;

    logic [N_REQ-1:0] w_gnt;
    logic [IDX_W-1:0] w_gnt_idx;
    logic             w_accept;
    logic [CNT_W-1:0] w_sel_delay;
    logic [IDX_W-1:0] w_next_ptr;
    logic [N_REQ-1:0] w_owner_onehot;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .i_req     (i_req_valid),
        .i_ptr     (r_rr_ptr),
        .i_en      (r_state == StIdle),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx)
    );

    always_comb begin
        w_sel_delay = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (w_gnt[i]) begin
                w_sel_delay = i_req_delay[i*CNT_W +: CNT_W];
            end
        end
    end

    assign w_accept       = |(i_req_valid & w_gnt);
    assign w_next_ptr     = IDX_W'(rr_next(32'(w_gnt_idx), N_REQ));
    assign w_owner_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << r_owner;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_count  <= '0;
            r_owner  <= '0;
            r_rr_ptr <= '0;
            r_done   <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_done <= '0;
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_count  <= w_sel_delay;
                        r_owner  <= w_gnt_idx;
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= StRun;
                        r_busy   <= 1'b1;
                    end
                end
                StRun: begin
                    // Abort wins even on the expiry cycle, so no done is issued.
                    if (i_abort) begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end else if (r_count != '0) begin
                        r_count <= r_count - 1'b1;
                    end else begin
                        r_state <= StDone;
                        r_done  <= w_owner_onehot;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_req_ready = w_gnt;
    assign o_done      = r_done;
    assign o_busy      = r_busy;
    assign o_owner     = r_owner;
    assign o_count     = r_count;

`ifdef FORMAL
    logic r_past_valid;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_past_valid <= 1'b0;
        else        r_past_valid <= 1'b1;
    end

    always_comb begin
        assert ($onehot0(o_req_ready));
        assert ($onehot0(o_done));
    end

    always_ff @(posedge clk) begin
        if (rst_n && r_past_valid && $past(rst_n)) begin
            if (!$past(w_accept)) assert (r_count <= $past(r_count));
            if (|o_done) assert ($past(r_state) == StRun && $past(r_count) == '0);
            cover ($past(r_state) == StRun && $past(i_abort));
        end
    end

    // Accepts granted to others while requester i keeps waiting.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_fair
        logic [IDX_W:0] r_wait;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_wait <= '0;
            end else if (!i_req_valid[gi] || (w_accept && w_gnt[gi])) begin
                r_wait <= '0;
            end else if (w_accept) begin
                r_wait <= r_wait + 1'b1;
            end
        end
        always_comb assert (32'(r_wait) < N_REQ);
        always_comb cover (o_done[gi]);
    end
`endif

endmodule

// File: tb/tb_delay_slot_scheduler.sv
// Scoreboard bench for delay_slot_scheduler: stimulus queues expected accepts and done pulses,
// a negedge monitor pops and compares them against what the scheduler presents.
module tb_delay_slot_scheduler;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_delay;
    logic [3:0]  req_ready;
    logic        abort;
    logic [3:0]  done;
    logic        busy;
    logic [1:0]  owner;
    logic [7:0]  count;

    typedef struct {
        int idx;
        int cyc;
    } ev_t;

    ev_t acc_q[$];
    ev_t done_q[$];
    int  cyc;
    int  n_checks;
    int  n_errors;

    delay_slot_scheduler #(
        .N_REQ (4),
        .CNT_W (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req_valid (req_valid),
        .i_req_delay (req_delay),
        .o_req_ready (req_ready),
        .i_abort     (abort),
        .o_done      (done),
        .o_busy      (busy),
        .o_owner     (owner),
        .o_count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_evt(input string name, input int act);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got %0d expected none (cycle %0d)", name, act, cyc);
    endtask

    function automatic int onehot_idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            ev_t e;
            chk("ready_onehot0", int'($onehot0(req_ready)), 1);
            chk("done_onehot0", int'($onehot0(done)), 1);
            if ((req_ready & req_valid) != 4'b0) begin
                if (acc_q.size() == 0) begin
                    fail_evt("unexpected_accept", onehot_idx(req_ready));
                end else begin
                    e = acc_q.pop_front();
                    chk("accept_idx", onehot_idx(req_ready), e.idx);
                    chk("accept_cycle", cyc, e.cyc);
                end
            end
            if (done != 4'b0) begin
                if (done_q.size() == 0) begin
                    fail_evt("unexpected_done", int'(done));
                end else begin
                    e = done_q.pop_front();
                    chk("done_vec", int'(done), 1 << e.idx);
                    chk("done_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present request idx for one cycle (DUT must be idle) and queue its expected events.
    task automatic do_req(input int idx, input logic [7:0] d, input bit exp_done);
        req_valid[idx]           = 1'b1;
        req_delay[idx*8 +: 8]    = d;
        acc_q.push_back('{idx: idx, cyc: cyc});
        if (exp_done) done_q.push_back('{idx: idx, cyc: cyc + int'(d) + 2});
        tick();
        req_valid[idx] = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        if (busy) fail_evt({name, "_idle_timeout"}, n);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int t;
        int busy_cycles;
        int prev;
        int wrapped;
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_delay = '0;
        abort     = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        chk("rst_busy", int'(busy), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_owner", int'(owner), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ready", int'(req_ready), 0);

        // Single request, delay 3.
        t = cyc;
        do_req(0, 8'd3, 1'b1);
        chk("single_cnt3", int'(count), 3);
        chk("single_busy", int'(busy), 1);
        chk("single_owner", int'(owner), 0);
        tick(); chk("single_cnt2", int'(count), 2);
        tick(); chk("single_cnt1", int'(count), 1);
        tick(); chk("single_cnt0", int'(count), 0);
        chk("single_ready_run", int'(req_ready), 0);
        tick();
        tick(); chk("single_idle", int'(busy), 0);
        tick();

        // Zero delay on requester 2.
        do_req(2, 8'd0, 1'b1);
        busy_cycles = 0;
        for (int k = 0; k < 5; k++) begin
            if (busy) busy_cycles++;
            tick();
        end
        chk("zero_busy_cycles", busy_cycles, 2);

        // Maximum delay on requester 1.
        do_req(1, 8'hFF, 1'b1);
        chk("maxd_cnt", int'(count), 255);
        prev    = int'(count);
        wrapped = 0;
        for (int k = 0; k < 256; k++) begin
            tick();
            if (int'(count) > prev) wrapped = 1;
            prev = int'(count);
        end
        chk("maxd_no_wrap", wrapped, 0);
        chk("maxd_cnt_end", int'(count), 0);
        wait_idle("maxd", 10);

        // Abort mid-slot; pending requester 0 takes over right away.
        t = cyc;
        do_req(3, 8'd10, 1'b0);
        req_valid[0]   = 1'b1;
        req_delay[7:0] = 8'd2;
        tick(); tick(); tick();
        abort = 1'b1;
        acc_q.push_back('{idx: 0, cyc: t + 5});
        done_q.push_back('{idx: 0, cyc: t + 9});
        tick();
        abort = 1'b0;
        chk("abort_cnt_held", int'(count), 7);
        chk("abort_busy", int'(busy), 0);
        chk("abort_ready", int'(req_ready), 1);
        tick();
        req_valid[0] = 1'b0;
        chk("abort_next_cnt", int'(count), 2);
        wait_idle("abort1", 10);

        // Abort ignored in IDLE, then abort on the count==0 cycle suppresses done.
        abort = 1'b1;
        do_req(1, 8'd2, 1'b0);
        abort = 1'b0;
        chk("abort_idle_ign", int'(busy), 1);
        tick(); tick();
        chk("abort0_cnt", int'(count), 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort0_busy", int'(busy), 0);
        repeat (4) tick();

        // Reset mid-slot.
        do_req(2, 8'd5, 1'b0);
        tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_count", int'(count), 0);
        chk("midrst_owner", int'(owner), 0);
        chk("midrst_done", int'(done), 0);
        tick(); tick();
        rst_n = 1'b1;

        // Round robin with all requesters valid; requester 0 first after reset.
        t         = cyc;
        req_delay = {8'd1, 8'd1, 8'd1, 8'd1};
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            acc_q.push_back('{idx: k % 4, cyc: t + 4 * k});
            done_q.push_back('{idx: k % 4, cyc: t + 4 * k + 3});
        end
        repeat (17) tick();
        req_valid = '0;
        wait_idle("rr", 10);
        repeat (3) tick();

        chk("acc_q_empty", acc_q.size(), 0);
        chk("done_q_empty", done_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/delay_slot_scheduler.md
Name: delay_slot_scheduler

Overview:
- Shares one CNT_W-bit down-counter among N_REQ requesters; each requester asks for a delay of D cycles.
- A round-robin arbiter grants one request at a time. The block loads the counter with D, counts it to zero and pulses a per-requester done.
- Sits beside the existing free-running counter in the formal examples area; it is the sequencing and sharing layer for the counter resource.

Parameters:
- N_REQ, 4, number of requesters (≥2).
- CNT_W, 8, counter and delay width in bits.
- IDX_W, $clog2(N_REQ), owner index width (derived, not overridden).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; asynchronous, active-low. Clock clk.
- req_valid  input  N_REQ  per-requester request; held until accepted.
- req_delay  input  N_REQ*CNT_W  per-requester delay; slice i is bits [i*CNT_W +: CNT_W]; stable while req_valid[i].
- req_ready  output  N_REQ  combinational one-hot grant; only in IDLE.
- abort  input  1  cancels the current timing slot.
- done  output  N_REQ  registered one-cycle pulse to the slot owner on expiry.
- busy  output  1  high in RUN or DONE.
- owner  output  IDX_W  index of the current or last granted requester.
- count  output  CNT_W  remaining count.

Behaviour:
- Reset values: state=IDLE, count=0, owner=0, done=0, busy=0, rr_ptr=0 (requester 0 has first priority).
- States:
  - IDLE: if any req_valid, the arbiter searches from rr_ptr upward with wrap and asserts req_ready[w] for winner w in the same cycle. Accept = req_valid[w]&req_ready[w]. On accept: count<=req_delay[w], owner<=w, rr_ptr<=(w+1) mod N_REQ, next=RUN. Without requests, stay in IDLE.
  - RUN: if abort, go to IDLE; count and done are unchanged. Else if count!=0, count<=count-1 and stay in RUN. Else (count==0) go to DONE.
  - DONE: done[owner]=1 for exactly this cycle. Next=IDLE even if abort is asserted; abort has no effect here.
- Latency: accept at cycle T gives RUN from T+1 to T+1+D, done pulse at T+D+2, and IDLE at T+D+3, so a new accept can happen in that cycle.
- D=0: one RUN cycle, done at T+2.
- D=2^CNT_W-1: no overflow; count only decrements and never wraps.
- abort in IDLE: ignored. abort in the same cycle as count==0 in RUN: abort wins and no done pulse is issued.
- req_ready is 0 in RUN and DONE. At most one req_ready bit and one done bit are set at any time.
- req_valid dropped before accept is a protocol violation. The design keeps no state for unaccepted requests.
- busy is registered and equals (state!=IDLE).
- Reset asserted mid-slot: immediate return to reset values; no done pulse.
- Formal (under FORMAL):
  - onehot0(req_ready) and onehot0(done).
  - count never increases except on accept.
  - done implies $past(state)==RUN and $past(count)==0.
  - Fairness: a requester holding valid is granted within N_REQ accepts.
  - Cover each done bit; cover abort.

Decomposition:
- Shared package delay_sched_pkg:
  - state enum {IDLE, RUN, DONE}.
  - Default N_REQ and CNT_W constants.
  - Function for the next round-robin pointer.
- One sub-module: rr_arbiter (parameters N_REQ, IDX_W).
  - Inputs: req, ptr, en. Outputs: one-hot grant and grant index.
  - Purely combinational. Reused by later multi-requester blocks.

Test Plan:
- Single request: req_valid=4'b0001, delay 3, accepted at T → done=4'b0001 at T+5 only; count sequence 3,2,1,0.
- Zero delay: requester 2, delay 0, accepted at T → done[2] at T+2; busy high for exactly 2 cycles.
- Round robin: all four valid continuously, delays 1 → grant order 0,1,2,3,0; rr_ptr wraps 3→0.
- Max delay: delay 8'hFF → done at T+257; count never wraps past 0.
- Abort: delay 10, abort at T+4 → no done pulse, IDLE at T+5, next pending request granted at T+5. Abort at the cycle with count==0 → no done.
- Reset mid-slot: rst_n low at T+3 of a delay-5 slot → all outputs 0 immediately; after release, requester 0 has priority.
